// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants, FSM state encoding and counter sizing for button_event_gen
package button_pkg;

    localparam logic BTN_RELEASED = 1'b1;
    localparam logic BTN_PRESSED  = 1'b0;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE   = 2'd0;
    localparam btn_state_t HOLD   = 2'd1;
    localparam btn_state_t REPEAT = 2'd2;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, debounce counter and press strobe for one button
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic held,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= BTN_RELEASED;
            sync2  <= BTN_RELEASED;
            stable <= BTN_RELEASED;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            // Any return to the accepted level restarts the qualification window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= (sync2 == BTN_PRESSED);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign held = (stable == BTN_PRESSED);

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - push_inc/push_dec event generator; auto-repeat enabled by BUTTON_AUTO_REPEAT_EN
module button_event_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_inc,
    input  logic button_dec,
    output logic push_inc,
    output logic push_dec,
    output logic held_inc,
    output logic held_dec
);

    logic [1:0] raw;
    logic [1:0] held_v;
    logic [1:0] press_v;
    logic [1:0] pulse_r;
    logic       conflict;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("button_event_gen: timing parameters must be at least 2");
    end

    assign raw = {button_dec, button_inc};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        btn_state_t state;
        logic       pulse;

        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .button(raw[c]),
            .held  (held_v[c]),
            .press (press_v[c])
        );

`ifdef BUTTON_AUTO_REPEAT_EN
        localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
        localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rcnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                state <= IDLE;
                rcnt  <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    IDLE: if (press_v[c]) begin
                        state <= HOLD;
                        rcnt  <= '0;
                        pulse <= 1'b1;
                    end
                    HOLD: if (!held_v[c]) begin
                        state <= IDLE;
                    end else if (rcnt == DELAY_LAST) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                        pulse <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                    REPEAT: if (!held_v[c]) begin
                        state <= IDLE;
                    end else if (rcnt == PERIOD_LAST) begin
                        rcnt  <= '0;
                        pulse <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
`else
        always_ff @(posedge clk) begin
            if (!reset) begin
                state <= IDLE;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    IDLE: if (press_v[c]) begin
                        state <= HOLD;
                        pulse <= 1'b1;
                    end
                    HOLD: if (!held_v[c]) begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
`endif

        assign pulse_r[c] = pulse;
    end

    // Both held, or both scheduled in one cycle (one releasing on this edge), is ambiguous: emit nothing.
    assign conflict = (&held_v) | (&pulse_r);

    assign push_inc = pulse_r[0] & ~conflict;
    assign push_dec = pulse_r[1] & ~conflict;
    assign held_inc = held_v[0];
    assign held_dec = held_v[1];

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - self-checking bench for button_event_gen with a window/schedule reference model
module tb_button_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk;
    logic reset;
    logic button_inc;
    logic button_dec;
    logic push_inc;
    logic push_dec;
    logic held_inc;
    logic held_dec;

    int vectors     = 0;
    int miscompares = 0;

    button_event_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button_inc(button_inc),
        .button_dec(button_dec),
        .push_inc  (push_inc),
        .push_dec  (push_dec),
        .held_inc  (held_inc),
        .held_dec  (held_dec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a level is accepted once the last DEB synchronised samples all disagree
    // with it; pulses fall on press_edge+1 (+RD, +RD+k*RP) while the level stays pressed.
    logic           m_r1[2];
    logic           m_r2[2];
    logic           m_stable[2];
    logic [DEB-1:0] m_win[2];
    int             m_fill[2];
    int             m_press[2];
    int             edge_n = 0;
    logic [3:0]     exp_v;

    task automatic model_edge(input logic rst, input logic raw_inc, input logic raw_dec);
        logic raw[2];
        logic fire[2];
        logic s2;
        logic h0;
        logic h1;
        int   k;
        raw[0] = raw_inc;
        raw[1] = raw_dec;
        edge_n++;
        for (int c = 0; c < 2; c++) begin
            fire[c] = 1'b0;
            if (!rst) begin
                m_r1[c]     = 1'b1;
                m_r2[c]     = 1'b1;
                m_stable[c] = 1'b1;
                m_win[c]    = '1;
                m_fill[c]   = 0;
                m_press[c]  = -1;
            end else begin
                s2       = m_r2[c];
                m_r2[c]  = m_r1[c];
                m_r1[c]  = raw[c];
                m_win[c] = {m_win[c][DEB-2:0], s2};
                if (m_fill[c] < DEB) m_fill[c]++;
                k = edge_n - m_press[c] - 1;
                if (m_stable[c] == 1'b0 && m_press[c] >= 0 && k == 0) fire[c] = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                if (m_stable[c] == 1'b0 && m_press[c] >= 0 && k >= RD && ((k - RD) % RP) == 0)
                    fire[c] = 1'b1;
`endif
                if (m_fill[c] == DEB && m_win[c] == {DEB{~m_stable[c]}}) begin
                    m_stable[c] = ~m_stable[c];
                    if (m_stable[c] == 1'b0) m_press[c] = edge_n;
                end
            end
        end
        h0 = ~m_stable[0];
        h1 = ~m_stable[1];
        exp_v = {fire[0] & ~(h0 & h1) & ~(fire[0] & fire[1]),
                 fire[1] & ~(h0 & h1) & ~(fire[0] & fire[1]), h0, h1};
    endtask

    task automatic step(input logic rst, input logic bi, input logic bd);
        @(negedge clk);
        reset      = rst;
        button_inc = bi;
        button_dec = bd;
        @(posedge clk);
        model_edge(rst, bi, bd);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 6; i++) begin
            step((i > 3), 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset step %0d: got %b expected 0000", i, {push_inc, push_dec, held_inc, held_dec});
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int count = 0;
        int fall  = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL clean_press step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (push_inc === 1'b1) begin
                count++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (first !== DEB + 3) begin
            miscompares++;
            $display("FAIL clean_press_latency: got %0d expected %0d", first, DEB + 3);
        end
        vectors++;
        if (count !== 1) begin
            miscompares++;
            $display("FAIL clean_press_count: got %0d expected 1", count);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL clean_release step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (held_inc === 1'b0 && fall < 0) fall = i;
        end
        vectors++;
        if (fall !== DEB + 2) begin
            miscompares++;
            $display("FAIL release_latency: got %0d expected %0d", fall, DEB + 2);
        end
    endtask

    task automatic test_bounce();
        int   first = -1;
        logic dropped = 1'b0;
        logic bd;
        for (int i = 0; i < 44; i++) begin
            if (i < 10)       bd = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            else if (i < 30)  bd = 1'b0;
            else if (i < 32)  bd = 1'b1;
            else              bd = 1'b0;
            step(1'b1, 1'b1, bd);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL bounce step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (push_dec === 1'b1 && first < 0) first = i;
            if (i >= 28 && held_dec !== 1'b1) dropped = 1'b1;
        end
        vectors++;
        if (first !== 16) begin
            miscompares++;
            $display("FAIL bounce_latency: got %0d expected 16", first);
        end
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_held: got dropped=%b expected 0", dropped);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_release step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int   got[$];
        int   want[$];
        int   fall = -1;
        logic ok;
        want.push_back(DEB + 3);
`ifdef BUTTON_AUTO_REPEAT_EN
        for (int t = DEB + 3 + RD; t <= 40; t += RP) want.push_back(t);
`endif
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL auto_repeat step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (push_inc === 1'b1) got.push_back(i);
        end
        ok = (got.size() == want.size());
        if (ok) for (int j = 0; j < want.size(); j++) if (got[j] != want[j]) ok = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL repeat_schedule: got %0d pulses expected %0d", got.size(), want.size());
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL repeat_release step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (held_inc === 1'b0 && fall < 0) fall = i;
        end
        vectors++;
        if (fall !== DEB + 2) begin
            miscompares++;
            $display("FAIL repeat_release_latency: got %0d expected %0d", fall, DEB + 2);
        end
    endtask

    task automatic test_simultaneous();
        int any_push = 0;
        int both_at  = -1;
        for (int i = 1; i <= 42; i++) begin
            step(1'b1, (i > 30), (i > 30));
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL simultaneous step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (push_inc === 1'b1 || push_dec === 1'b1) any_push++;
            if (held_inc === 1'b1 && held_dec === 1'b1 && both_at < 0) both_at = i;
        end
        vectors++;
        if (any_push !== 0 || both_at !== DEB + 2) begin
            miscompares++;
            $display("FAIL simultaneous_summary: got pushes=%0d held_at=%0d expected 0 and %0d", any_push, both_at, DEB + 2);
        end
    endtask

    task automatic test_conflict_release();
        int first = -1;
        int want;
`ifdef BUTTON_AUTO_REPEAT_EN
        want = DEB + 3 + RD + 2 * RP;
`else
        want = -1;
`endif
        for (int i = 1; i <= 45; i++) begin
            step(1'b1, 1'b0, (i >= 20));
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL conflict step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (push_inc === 1'b1 && first < 0) first = i;
        end
        vectors++;
        if (first !== want) begin
            miscompares++;
            $display("FAIL conflict_resume: got %0d expected %0d", first, want);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL conflict_release step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int first = -1;
        for (int i = 1; i <= 35; i++) begin
            step((i != 15), 1'b0, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL reset_hold step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            if (i == 15) begin
                vectors++;
                if ({push_inc, push_dec, held_inc, held_dec} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_hold_clear: got %b expected 0000", {push_inc, push_dec, held_inc, held_dec});
                end
            end
            if (i > 15 && push_inc === 1'b1 && first < 0) first = i - 15;
        end
        vectors++;
        if (first !== DEB + 3) begin
            miscompares++;
            $display("FAIL reset_hold_latency: got %0d expected %0d", first, DEB + 3);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL reset_hold_release step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic bi = 1'b1;
        logic bd = 1'b1;
        logic rs;
        for (int i = 1; i <= 1500; i++) begin
            if ($urandom_range(0, 9) == 0) bi = ~bi;
            if ($urandom_range(0, 11) == 0) bd = ~bd;
            rs = ($urandom_range(0, 199) != 0);
            step(rs, bi, bd);
            vectors++;
            if ({push_inc, push_dec, held_inc, held_dec} !== exp_v) begin
                miscompares++;
                $display("FAIL random step %0d: got %b expected %b", i, {push_inc, push_dec, held_inc, held_dec}, exp_v);
            end
            vectors++;
            if ((push_inc & push_dec) !== 1'b0) begin
                miscompares++;
                $display("FAIL random_exclusive step %0d: got %b expected 0", i, push_inc & push_dec);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        button_inc = 1'b1;
        button_dec = 1'b1;
        model_edge(1'b0, 1'b1, 1'b1);
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_conflict_release();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Front-end that produces the single-cycle push_inc/push_dec event pulses consumed by the LED counter logic.
- Takes two raw, asynchronous, active-low board buttons.
- Synchronises, debounces and edge-detects each one.
- Optionally generates auto-repeat pulses while a button is held.
- Sits between the board pins and any up/down counter in the design.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised level must stay changed before it is accepted (>=2)
REPEAT_DELAY, 25000000, held cycles after the initial pulse before the first repeat pulse (>=2)
REPEAT_PERIOD, 5000000, cycles between successive repeat pulses (>=2)

Ports:
clk  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
button_inc  in  1  raw increment button, active-low (0 = pressed), asynchronous
button_dec  in  1  raw decrement button, active-low (0 = pressed), asynchronous
push_inc  out  1  one-cycle increment event pulse
push_dec  out  1  one-cycle decrement event pulse
held_inc  out  1  debounced pressed level of increment button (1 = pressed)
held_dec  out  1  debounced pressed level of decrement button (1 = pressed)

Behaviour:
- One clock (clk). Reset is synchronous and active-low: reset sampled 0 on a clk edge resets all state.
- Reset state:
  - sync and stable registers = 1 (released).
  - Counters = 0; FSMs = IDLE.
  - push_* = 0, held_* = 0.
- Synchroniser: two flops per button.
- Debounce, per channel:
  - If sync2 == stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and the counter clears.
  - Width = clog2(DEBOUNCE_CYCLES); no wrap is possible.
- held_x = ~stable_x, combinational from the register.
- Press latency: raw level settles before clk edge 1 -> push_x is high for exactly the cycle following edge DEBOUNCE_CYCLES+3 (L = DEBOUNCE_CYCLES+3).
- Release: produces no pulse. held_x falls at edge DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES in either direction are ignored completely.
- Per-channel FSM (registered push_x, driven on state entry/event):
  - IDLE: on stable falling edge (press) -> HOLD, pulse 1 cycle, clear repeat counter.
  - HOLD: count to REPEAT_DELAY-1 -> REPEAT with pulse; release -> IDLE.
  - REPEAT: pulse every REPEAT_PERIOD cycles; release -> IDLE immediately, no pulse.
- Conflict rule: in any cycle where both held_inc and held_dec are 1, both push outputs are forced 0.
  - FSMs and counters keep running.
  - Pulses resume on their normal schedule once only one button remains held.
  - Two presses accepted in the same cycle produce no pulses.
- Reset while a button is held:
  - Outputs clear next edge.
  - After reset is released with the button still low, that button is treated as a new press: pulse at L cycles after the reset-release edge.
- push_inc and push_dec are never high in the same cycle.

Optional Feature:
Macro BUTTON_AUTO_REPEAT_EN.
- Defined: HOLD/REPEAT timing as above.
- Undefined: HOLD and REPEAT never emit pulses; only the initial press pulse exists. Repeat counters and the REPEAT_* parameters are unused and optimised away. held_* and the conflict rule are unchanged.

Decomposition:
Package button_pkg:
- BTN_RELEASED = 1'b1, BTN_PRESSED = 1'b0.
- FSM state typedef: IDLE, HOLD, REPEAT (2-bit).
- clog2-based counter width helper.
Sub-module button_debouncer:
- Instantiated twice.
- Contains synchroniser, debounce counter and stable register.
- Outputs held level and a one-cycle press strobe.
FSMs and conflict masking stay in button_event_gen.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: button_inc 1->0 before edge 1, held 12 cycles -> push_inc high exactly in cycle 7, held_inc=1 from edge 6, push_dec never high. Without macro: no further pulses.
- Bounce: button_dec toggles every 2 cycles for 10 cycles then stays 0 -> single push_dec exactly 7 cycles after final settle; 2-cycle high glitch mid-hold -> no pulse, held_dec stays 1.
- Auto-repeat (BUTTON_AUTO_REPEAT_EN): button_inc held 40 cycles -> push_inc at cycles 7, 17, 22, 27, 32, 37. Release -> no pulse, held_inc falls 6 cycles after the release edge.
- Simultaneous press: both buttons 1->0 same cycle, held 30 cycles -> push_inc=push_dec=0 throughout, held_inc=held_dec=1.
- Conflict release (with macro): button_dec released at cycle 20 while inc held -> push_inc resumes on the inc repeat schedule after held_dec falls.
- Reset mid-hold: reset=0 for 1 cycle at cycle 15 with button_inc held -> all outputs 0 next edge; new push_inc exactly 7 cycles after the reset-release edge.
